tetris_cmd_scheduler: RTL and testbench
=======================================

// Module: tetris_cmd_scheduler
// PURPOSE
//  Sequences the tetris grid engine. Collects player requests (left, right, rotate, pause) and the gravity tick.
//  Issues one command at a time over a valid/ready handshake. Player requests get auto-repeat (DAS).
//  Gravity speeds up with level; level is derived from rows cleared.
//  Sits between the synchronised input front-end and the grid/game-state datapath.
// PARAMETERS
//  GRAVITY_BASE     40_000_000  gravity period in clk cycles at level 0
//  GRAVITY_STEP     3_000_000   period reduction per level
//  GRAVITY_MIN      4_000_000   lowest normal gravity period (floor)
//  SOFT_PERIOD      2_000_000   gravity period while btn_down held (overrides level)
//  DAS_DELAY        10_000_000  cycles a left/right button is held before auto-repeat starts
//  DAS_RATE         2_000_000   cycles between auto-repeats
//  LINES_PER_LEVEL  10          cleared rows per level increment
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   asynchronous active-low reset
//  btn_left        in   1   left request, level, already synchronised
//  btn_right       in   1   right request, level
//  btn_down        in   1   soft-drop, level
//  btn_rotate      in   1   rotate request, level
//  btn_pause       in   1   pause toggle, level
//  row_cleared     in   1   level from grid; each rising edge = one cleared row
//  game_over       in   1   level from grid; sticky once high
//  cmd_ready       in   1   grid accepts cmd this cycle
//  cmd_valid       out  1   command offered
//  cmd_code        out  3   1 LEFT, 2 RIGHT, 3 ROTATE, 4 GRAVITY, 5 PAUSE, 6 RESUME; 0 when !cmd_valid
//  paused          out  1   scheduler in PAUSED state
//  level           out  4   current level, saturates at 15
//  lines           out  8   total rows cleared, saturates at 255
//  gravity_period  out  26  active gravity period in cycles
// BEHAVIOUR
//  Reset values:
//   - state=RUN; cmd_valid=0, cmd_code=0, paused=0, level=0, lines=0, gravity_period=GRAVITY_BASE.
//   - All pending flags, the gravity counter and the DAS counters are 0.
//   - Edge registers reset to 0, so a button already held at reset release counts as a press.
//  Reset mid-handshake drops the command.
//  FSM:
//   - RUN -> PAUSED on a rising edge of btn_pause.
//   - PAUSED -> RUN on the next rising edge of btn_pause.
//   - RUN or PAUSED -> OVER when game_over=1. OVER holds until reset.
//   - In OVER: cmd_valid=0, and no pending flags are set.
//  Pending flags:
//   - One flag each for pause, gravity, rotate, left and right.
//   - A flag is set by its event and cleared only by the transfer that carries it.
//   - An event that arrives while its flag is already set is dropped, not queued.
//  Rotate and pause events are rising edges of their buttons.
//  Gravity counter:
//   - Counts only in RUN.
//   - When count == gravity_period-1: counter returns to 0 and grav_pending is set.
//   - Frozen, not cleared, in PAUSED.
//  Soft drop: gravity_period = SOFT_PERIOD while btn_down=1. The counter is clamped to the new period-1 if it is above it.
//  Left/right DAS, per direction:
//   - The press edge sets the flag.
//   - Held DAS_DELAY cycles: the flag is set again, then again every DAS_RATE cycles while held.
//   - Release zeroes the DAS counter.
//   - btn_left and btn_right both high: neither flag is set, and both DAS counters clear.
//  Arbitration: fixed priority PAUSE > GRAVITY > ROTATE > LEFT > RIGHT. The winner is latched into cmd_code when cmd_valid rises.
//  Handshake:
//   - cmd_valid/cmd_code stay stable until a cycle with cmd_ready=1.
//   - The transfer happens on that posedge and clears that flag.
//   - A new command may be valid in the next cycle (back-to-back allowed).
//   - A cycle with cmd_ready=0 never drops or changes the offered command.
//  In PAUSED only RESUME (code 6) can be issued. Other flags are retained, and no new player or gravity events are latched.
//  The pause press in RUN issues PAUSE (5) to the grid.
//  Lines and level:
//   - lines increments by one per row_cleared rising edge, saturating at 255.
//   - An internal modulo counter bumps level every LINES_PER_LEVEL lines, saturating at 15.
//   - Normal period = max(GRAVITY_BASE - level*GRAVITY_STEP, GRAVITY_MIN). It is registered, so it updates 1 cycle after level changes.
//  All arithmetic is unsigned 26-bit. The subtraction is guarded against underflow, i.e. the floor applies.
// TESTING  (GRAVITY_BASE=100, GRAVITY_STEP=10, GRAVITY_MIN=20, SOFT_PERIOD=8, DAS_DELAY=16, DAS_RATE=4, LINES_PER_LEVEL=2)
//  1. Idle with cmd_ready=1 -> cmd_code=4 transfers every 100 cycles; no other codes.
//  2. Hold btn_left 40 cycles with ready=1 -> LEFT at the press edge, then at +16, +20, +24 ... (7 total). Both buttons held -> no LEFT/RIGHT.
//  3. btn_rotate edge with the gravity flag also pending, and cmd_ready=0 for 5 cycles -> GRAVITY held stable; on ready, GRAVITY then ROTATE on consecutive cycles.
//  4. Pause edge -> PAUSE issued, paused=1, gravity counter frozen at its value. Second edge -> RESUME; the next GRAVITY arrives after the remaining count.
//  5. Six row_cleared pulses -> lines=6, level=3, gravity_period=70. With btn_down held -> 8. Twenty pulses -> level=10, period=20 (floor).
//  6. game_over=1 mid-handshake -> cmd_valid=0 the next cycle, and none thereafter. reset_n low -> all outputs at reset values immediately.

Source files
------------

// File: rtl/tetris_cmd_scheduler.sv
// Purpose: turns player buttons, gravity ticks and cleared rows into one command stream for the tetris grid engine.
// Latency: a command is offered two cycles after its triggering edge; back-to-back transfers can occur on consecutive cycles.
// Backpressure: cmd_valid/cmd_code hold until cmd_ready; an event that finds its flag already pending is dropped.
module tetris_cmd_scheduler #(
  parameter int unsigned GRAVITY_BASE    = 40_000_000,
  parameter int unsigned GRAVITY_STEP    = 3_000_000,
  parameter int unsigned GRAVITY_MIN     = 4_000_000,
  parameter int unsigned SOFT_PERIOD     = 2_000_000,
  parameter int unsigned DAS_DELAY       = 10_000_000,
  parameter int unsigned DAS_RATE        = 2_000_000,
  parameter int unsigned LINES_PER_LEVEL = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        btn_rotate,
  input  logic        btn_pause,
  input  logic        row_cleared,
  input  logic        game_over,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        paused,
  output logic [3:0]  level,
  output logic [7:0]  lines,
  output logic [25:0] gravity_period
);

  localparam logic [25:0] P_BASE      = 26'(GRAVITY_BASE);
  localparam logic [25:0] P_STEP      = 26'(GRAVITY_STEP);
  localparam logic [25:0] P_MIN       = 26'(GRAVITY_MIN);
  localparam logic [25:0] P_SOFT      = 26'(SOFT_PERIOD);
  localparam logic [25:0] P_DAS_DELAY = 26'(DAS_DELAY);
  localparam logic [25:0] P_DAS_RPT   = 26'(DAS_DELAY - DAS_RATE + 1);
  localparam logic [7:0]  P_LPL_LAST  = 8'(LINES_PER_LEVEL - 1);

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_LEFT    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_ROTATE  = 3'd3;
  localparam logic [2:0] CMD_GRAVITY = 3'd4;
  localparam logic [2:0] CMD_PAUSE   = 3'd5;
  localparam logic [2:0] CMD_RESUME  = 3'd6;

  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_OVER} state_t;

  state_t             state, state_nxt;
  logic               pause_take;
  logic [1:0]         lr_btn, lr_prev, lr_solo, lr_evt;
  logic [1:0][25:0]   das_cnt, das_nxt;
  logic               prev_rotate, prev_pause, prev_row;
  logic               pause_evt, rot_evt, row_evt, in_run;
  logic [25:0]        grav_cnt, grav_last, norm_period, norm_calc, level_dec;
  logic               grav_evt;
  logic               pend_pause, pend_grav, pend_rot, pend_left, pend_right;
  logic [2:0]         pause_code;
  logic               xfer, clr_pause, clr_grav, clr_rot, clr_left, clr_right;
  logic               win_vld;
  logic [2:0]         win_code;
  logic [7:0]         lvl_cnt;

  assign lr_btn    = {btn_right, btn_left};
  assign lr_solo   = lr_btn & ~{btn_left, btn_right};
  assign pause_evt = btn_pause & ~prev_pause;
  assign rot_evt   = btn_rotate & ~prev_rotate;
  assign row_evt   = row_cleared & ~prev_row;
  assign in_run    = (state == ST_RUN);
  assign paused    = (state == ST_PAUSED);

  // Input history for rising-edge detection; zero at reset so a held button counts as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev <= '0; prev_rotate <= 1'b0; prev_pause <= 1'b0; prev_row <= 1'b0;
    end else begin
      lr_prev <= lr_btn; prev_rotate <= btn_rotate; prev_pause <= btn_pause; prev_row <= row_cleared;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Next state; a pause press that finds the pause flag still pending is ignored entirely.
  always_comb begin
    state_nxt  = state;
    pause_take = 1'b0;
    case (state)
      ST_RUN, ST_PAUSED: begin
        pause_take = pause_evt & ~pend_pause & ~game_over;
        if (game_over)       state_nxt = ST_OVER;
        else if (pause_take) state_nxt = in_run ? ST_PAUSED : ST_RUN;
      end
      default: state_nxt = ST_OVER;
    endcase
  end

  // Auto-repeat per direction: press fires, then DAS_DELAY cycles later, then every DAS_RATE while held alone.
  always_comb begin
    das_nxt = '0;
    lr_evt  = '0;
    for (int i = 0; i < 2; i++) begin
      if (in_run && lr_solo[i]) begin
        if (!lr_prev[i]) begin
          das_nxt[i] = 26'd1;
          lr_evt[i]  = 1'b1;
        end else if (das_cnt[i] == P_DAS_DELAY) begin
          das_nxt[i] = P_DAS_RPT;
          lr_evt[i]  = 1'b1;
        end else begin
          das_nxt[i] = das_cnt[i] + 26'd1;
        end
      end
    end
  end

  // DAS counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) das_cnt <= '0;
    else          das_cnt <= das_nxt;
  end

  // Soft drop overrides the level-derived period.
  assign gravity_period = btn_down ? P_SOFT : norm_period;
  assign grav_last      = gravity_period - 26'd1;
  assign grav_evt       = in_run && (grav_cnt == grav_last);

  // Gravity counter: runs only in RUN, frozen otherwise, clamped when the period shrinks below it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) grav_cnt <= '0;
    else if (in_run) begin
      if (grav_cnt > grav_last)       grav_cnt <= grav_last;
      else if (grav_cnt == grav_last) grav_cnt <= '0;
      else                            grav_cnt <= grav_cnt + 26'd1;
    end
  end

  assign xfer      = cmd_valid & cmd_ready;
  assign clr_pause = xfer && (cmd_code == CMD_PAUSE || cmd_code == CMD_RESUME);
  assign clr_grav  = xfer && (cmd_code == CMD_GRAVITY);
  assign clr_rot   = xfer && (cmd_code == CMD_ROTATE);
  assign clr_left  = xfer && (cmd_code == CMD_LEFT);
  assign clr_right = xfer && (cmd_code == CMD_RIGHT);

  // Pending flags: set by their event only when clear, cleared only by the transfer carrying them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_pause <= 1'b0; pend_grav <= 1'b0; pend_rot <= 1'b0;
      pend_left  <= 1'b0; pend_right <= 1'b0; pause_code <= CMD_PAUSE;
    end else if (state_nxt == ST_OVER) begin
      pend_pause <= 1'b0; pend_grav <= 1'b0; pend_rot <= 1'b0;
      pend_left  <= 1'b0; pend_right <= 1'b0;
    end else begin
      pend_pause <= pend_pause ? ~clr_pause : pause_take;
      if (pause_take) pause_code <= in_run ? CMD_PAUSE : CMD_RESUME;
      pend_grav  <= pend_grav  ? ~clr_grav  : grav_evt;
      pend_rot   <= pend_rot   ? ~clr_rot   : (in_run & rot_evt);
      pend_left  <= pend_left  ? ~clr_left  : lr_evt[0];
      pend_right <= pend_right ? ~clr_right : lr_evt[1];
    end
  end

  // Fixed-priority winner among flags still pending after this cycle's transfer; outside RUN only pause/resume.
  always_comb begin
    win_vld  = 1'b1;
    win_code = CMD_NONE;
    if (pend_pause && !clr_pause)       win_code = pause_code;
    else if (state_nxt != ST_RUN)       win_vld  = 1'b0;
    else if (pend_grav && !clr_grav)    win_code = CMD_GRAVITY;
    else if (pend_rot && !clr_rot)      win_code = CMD_ROTATE;
    else if (pend_left && !clr_left)    win_code = CMD_LEFT;
    else if (pend_right && !clr_right)  win_code = CMD_RIGHT;
    else                                win_vld  = 1'b0;
  end

  // Command register: loads only when empty or transferring, so a stalled offer never changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0; cmd_code <= CMD_NONE;
    end else if (state_nxt == ST_OVER) begin
      cmd_valid <= 1'b0; cmd_code <= CMD_NONE;
    end else if (!cmd_valid || cmd_ready) begin
      cmd_valid <= win_vld; cmd_code <= win_code;
    end
  end

  // Rows cleared and level, both saturating; lvl_cnt is the modulo counter within a level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lines <= '0; level <= '0; lvl_cnt <= '0;
    end else if (row_evt) begin
      if (lines != 8'hFF) lines <= lines + 8'd1;
      if (lvl_cnt == P_LPL_LAST) begin
        lvl_cnt <= '0;
        if (level != 4'hF) level <= level + 4'd1;
      end else begin
        lvl_cnt <= lvl_cnt + 8'd1;
      end
    end
  end

  // Level-derived period with an underflow-safe floor.
  always_comb begin
    level_dec = 26'(level) * P_STEP;
    norm_calc = P_MIN;
    if (P_BASE > level_dec && (P_BASE - level_dec) > P_MIN) norm_calc = P_BASE - level_dec;
  end

  // Registered normal period, one cycle behind level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) norm_period <= P_BASE;
    else          norm_period <= norm_calc;
  end

endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Bench for tetris_cmd_scheduler with shortened periods.
// Expected transfers (code, cycles since previous transfer or reset) are queued at stimulus time
// and popped by a monitor when the DUT completes a handshake.
module tb_tetris_cmd_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rotate = 1'b0, btn_pause = 1'b0;
  logic        row_cleared = 1'b0, game_over = 1'b0, cmd_ready = 1'b0;
  logic        cmd_valid, paused;
  logic [2:0]  cmd_code;
  logic [3:0]  level;
  logic [7:0]  lines;
  logic [25:0] gravity_period;

  always #5 clk = ~clk;

  tetris_cmd_scheduler #(
    .GRAVITY_BASE(100), .GRAVITY_STEP(10), .GRAVITY_MIN(20), .SOFT_PERIOD(8),
    .DAS_DELAY(16), .DAS_RATE(4), .LINES_PER_LEVEL(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .btn_rotate(btn_rotate), .btn_pause(btn_pause), .row_cleared(row_cleared), .game_over(game_over),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .paused(paused),
    .level(level), .lines(lines), .gravity_period(gravity_period)
  );

  typedef struct {int code; int gap;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0, last_xfer = 0, extra_cnt = 0, n_chk = 0, n_pass = 0, seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic expect_xfer(input int code, input int gap);
    exp_t e;
    e.code = code;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  // Handshake monitor: ready is stable from #1 after one posedge to the next, so negedge sees the transfer.
  always @(negedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) extra_cnt++;
      else begin
        mon_e = exp_q.pop_front();
        check("xfer_code", int'(cmd_code), mon_e.code);
        if (mon_e.gap >= 0) check("xfer_gap", cyc + 1 - last_xfer, mon_e.gap);
      end
      last_xfer = cyc + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_left = 0; btn_right = 0; btn_down = 0; btn_rotate = 0; btn_pause = 0;
    row_cleared = 0; game_over = 0; cmd_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    last_xfer = cyc;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !cmd_valid; i++) step(1);
  endtask

  task automatic pulse_rows(input int n);
    for (int i = 0; i < n; i++) begin
      row_cleared = 1'b1; step(1);
      row_cleared = 1'b0; step(1);
    end
  endtask

  task automatic end_section(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_extra"}, extra_cnt, 0);
    exp_q.delete();
    extra_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(cmd_valid), 0);
    check({tag, "_code"}, int'(cmd_code), 0);
    check({tag, "_paused"}, int'(paused), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_lines"}, int'(lines), 0);
    check({tag, "_period"}, int'(gravity_period), 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    // Reset state.
    @(negedge clk);
    check_reset_outputs("rst");

    // 1: idle gravity every 100 cycles.
    do_reset();
    cmd_ready = 1'b1;
    expect_xfer(4, 102); expect_xfer(4, 100); expect_xfer(4, 100);
    wait_drain(400); step(2);
    end_section("t1");

    // 2: left auto-repeat, both held, single right.
    do_reset();
    cmd_ready = 1'b1; btn_left = 1'b1;
    expect_xfer(1, 3); expect_xfer(1, 16);
    for (int i = 0; i < 5; i++) expect_xfer(1, 4);
    step(40); btn_left = 1'b0;
    wait_drain(20); step(5);
    end_section("t2_left");
    do_reset();
    cmd_ready = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    step(40); btn_left = 1'b0; btn_right = 1'b0;
    step(5);
    end_section("t2_both");
    btn_right = 1'b1;
    expect_xfer(2, 48);
    step(3); btn_right = 1'b0;
    wait_drain(10); step(2);
    end_section("t2_right");

    // 3: stalled gravity stays stable, then gravity and rotate back to back.
    do_reset();
    wait_valid(200);
    check("t3_valid", int'(cmd_valid), 1);
    btn_rotate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t3_hold_vld", int'(cmd_valid), 1);
      check("t3_hold_code", int'(cmd_code), 4);
    end
    expect_xfer(4, -1); expect_xfer(3, 1);
    cmd_ready = 1'b1;
    wait_drain(10); btn_rotate = 1'b0; step(2);
    end_section("t3");

    // 4: pause freezes gravity; resume continues from the frozen count.
    do_reset();
    cmd_ready = 1'b1;
    step(30);
    btn_pause = 1'b1;
    expect_xfer(5, 33);
    step(3); btn_pause = 1'b0;
    check("t4_paused", int'(paused), 1);
    step(40);
    check("t4_still_paused", int'(paused), 1);
    btn_pause = 1'b1;
    expect_xfer(6, 43); expect_xfer(4, 69);
    step(3); btn_pause = 1'b0;
    check("t4_resumed", int'(paused), 0);
    wait_drain(100); step(2);
    end_section("t4");

    // 5: lines, level, period floor and saturation; soft drop.
    do_reset();
    pulse_rows(6); step(2);
    check("t5_lines6", int'(lines), 6);
    check("t5_level3", int'(level), 3);
    check("t5_period70", int'(gravity_period), 70);
    btn_down = 1'b1; #1;
    check("t5_soft_period", int'(gravity_period), 8);
    btn_down = 1'b0;
    pulse_rows(14); step(2);
    check("t5_lines20", int'(lines), 20);
    check("t5_level10", int'(level), 10);
    check("t5_period_floor", int'(gravity_period), 20);
    pulse_rows(20); step(2);
    check("t5_level_sat", int'(level), 15);
    check("t5_period_sat", int'(gravity_period), 20);
    pulse_rows(220); step(2);
    check("t5_lines_sat", int'(lines), 255);
    end_section("t5");

    // 5b: soft drop clamps the running counter, then gravity every 8 cycles.
    do_reset();
    cmd_ready = 1'b1;
    step(50);
    btn_down = 1'b1;
    expect_xfer(4, 54); expect_xfer(4, 8);
    wait_drain(40); btn_down = 1'b0; step(2);
    end_section("t5_soft");

    // 6a: game over mid-handshake kills the offer for good.
    do_reset();
    wait_valid(200);
    check("t6_pre_valid", int'(cmd_valid), 1);
    game_over = 1'b1;
    step(1);
    check("t6_over_valid", int'(cmd_valid), 0);
    check("t6_over_code", int'(cmd_code), 0);
    cmd_ready = 1'b1; btn_left = 1'b1; btn_rotate = 1'b1;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (cmd_valid) seen++;
    end
    game_over = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (cmd_valid) seen++;
    end
    check("t6_over_quiet", seen, 0);
    btn_left = 1'b0; btn_rotate = 1'b0;
    end_section("t6_over");

    // 6b: asynchronous reset mid-handshake with non-default counters.
    do_reset();
    pulse_rows(4);
    wait_valid(200);
    check("t6_pre_lines", int'(lines), 4);
    check("t6_pre_valid2", int'(cmd_valid), 1);
    reset_n = 1'b0;
    #2;
    check_reset_outputs("t6_async");
    do_reset();
    end_section("t6_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
